// File: rtl/mips32_pkg.sv
// mips32_pkg: requester indices, FSM encoding and width defaults shared by the arbiter files.
// Rev 1.0
`default_nettype none

package mips32_pkg;

   localparam int NUM_REQ    = 3;
   localparam int REQ_DATA   = 0;
   localparam int REQ_FETCH  = 1;
   localparam int REQ_LOAD   = 2;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Requesters eligible for a grant in each state
   function automatic logic [NUM_REQ-1:0] state_mask(input logic [1:0] st);
      logic [NUM_REQ-1:0] m;
      m = '0;
      case (st)
         ST_RUN:    m = 3'b111;
         ST_DRAIN:  m = 3'b101;
         ST_HALTED: m = 3'b100;
         default:   m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips32_prio_sel.sv
// mips32_prio_sel: fixed-priority one-hot selector (data > fetch > loader) with mask and loader force.
// Rev 1.0
`default_nettype none

module mips32_prio_sel
   import mips32_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] mask_i,
   input  logic               force_load_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic [NUM_REQ-1:0] elig;

   always_comb begin
      elig  = req_i & mask_i;
      gnt_o = '0;
      if (force_load_i && elig[REQ_LOAD]) begin
         gnt_o[REQ_LOAD] = 1'b1;
      end else if (elig[REQ_DATA]) begin
         gnt_o[REQ_DATA] = 1'b1;
      end else if (elig[REQ_FETCH]) begin
         gnt_o[REQ_FETCH] = 1'b1;
      end else if (elig[REQ_LOAD]) begin
         gnt_o[REQ_LOAD] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: single-port memory arbiter for data/fetch/loader with loader anti-starvation
// and a RUN/DRAIN/HALTED debug FSM. Rev 1.0
`default_nettype none

module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        rvalid_o,
   output logic [DATA_W-1:0]         rdata_o,
   input  logic                      halt_req_i,
   input  logic                      resume_i,
   output logic                      halted_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic [DATA_W-1:0]         mem_rdata_i
);

   logic [1:0]         state_q, state_d;
   logic [3:0]         starve_q, starve_d;
   logic [NUM_REQ-1:0] rtag_q, rtag_d;
   logic [NUM_REQ-1:0] sel_gnt;
   logic               force_load;
   logic               rd_issue;
   logic [ADDR_W-1:0]  addr_s  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_s [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_s[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_s[gi] = wdata_i[gi*DATA_W +: DATA_W];
   end

   assign force_load = (state_q == ST_RUN) && (starve_q == 4'(STARVE_LIMIT));

   mips32_prio_sel u_prio_sel (
      .req_i        (req_i),
      .mask_i       (state_mask(state_q)),
      .force_load_i (force_load),
      .gnt_o        (sel_gnt)
   );

   // Grants are combinational, so they must also be suppressed while reset is held
   assign gnt_o    = rst_n ? sel_gnt : '0;
   assign rtag_d   = gnt_o & ~we_i;
   assign rd_issue = |rtag_d;

   always_comb begin
      mem_en_o    = |gnt_o;
      mem_we_o    = |(gnt_o & we_i);
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_o[i]) begin
            mem_addr_o  = addr_s[i];
            mem_wdata_o = wdata_s[i];
         end
      end
   end

   assign rvalid_o = rtag_q;
   assign rdata_o  = (|rtag_q) ? mem_rdata_i : '0;
   assign halted_o = (state_q == ST_HALTED);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (halt_req_i) state_d = ST_DRAIN;
         // A read returning this cycle is complete; only one issued now keeps us draining
         ST_DRAIN:  if (!req_i[REQ_DATA] && !rd_issue) state_d = ST_HALTED;
         ST_HALTED: if (resume_i) state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase

      starve_d = starve_q;
      if (!req_i[REQ_LOAD] || gnt_o[REQ_LOAD]) begin
         starve_d = '0;
      end else if ((state_q == ST_RUN) && (starve_q < 4'(STARVE_LIMIT))) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         starve_q <= '0;
         rtag_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         rtag_q   <= rtag_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: scoreboard bench with a cycle-level reference model of the arbiter rules.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mips32_mem_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int LIM = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      req = '0;
   logic [2:0]      we  = '0;
   logic [3*AW-1:0] addr  = '0;
   logic [3*DW-1:0] wdata = '0;
   logic            halt_req = 1'b0;
   logic            resume   = 1'b0;
   logic [2:0]      gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic            halted, mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .halt_req_i(halt_req), .resume_i(resume),
      .halted_o(halted), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // Synchronous-read memory device
   logic [DW-1:0] dev_mem [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) dev_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= dev_mem[mem_addr];
      end
   end

   // Reference model state
   typedef enum int {M_RUN, M_DRAIN, M_HALT} mode_t;
   typedef struct { int due; int idx; logic [DW-1:0] data; } rd_t;
   mode_t         m_mode = M_RUN;
   int            m_wait = 0;
   logic [DW-1:0] ref_mem [0:1023];
   rd_t           rq[$];
   int            cyc = 0, checks = 0, errors = 0;
   logic [2:0]    gseen = '0;
   int            last_gnt_cyc [3] = '{-1, -1, -1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [2:0]    allowed, eg;
      int            gi;
      logic [AW-1:0] ga;
      if (!rst_n) begin
         rq.delete();
         m_mode = M_RUN;
         m_wait = 0;
         gseen  = '0;
         chk("rst_gnt", gnt, 0);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_halted", halted, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
      end else begin
         cyc++;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rvalid", rvalid, 64'(1) << rq[0].idx);
            chk("rdata", rdata, rq[0].data);
            void'(rq.pop_front());
         end else begin
            chk("rvalid_idle", rvalid, 0);
         end

         // Eligible requesters: everyone in RUN, fetch excluded while draining, loader only when halted
         case (m_mode)
            M_RUN:   allowed = req;
            M_DRAIN: allowed = req & 3'b101;
            default: allowed = req & 3'b100;
         endcase
         eg = '0;
         gi = -1;
         if (m_mode == M_RUN && m_wait == LIM && allowed[2]) begin
            eg = 3'b100;
            gi = 2;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (gi < 0 && allowed[k]) begin
                  eg = 3'(1 << k);
                  gi = k;
               end
            end
         end

         chk("gnt", gnt, eg);
         chk("halted", halted, m_mode == M_HALT);
         chk("mem_en", mem_en, gi >= 0);
         chk("mem_we", mem_we, gi >= 0 && we[gi]);
         for (int k = 0; k < 3; k++) if (gnt[k]) last_gnt_cyc[k] = cyc;

         if (gi >= 0) begin
            ga = addr[gi*AW +: AW];
            chk("mem_addr", mem_addr, ga);
            if (we[gi]) begin
               chk("mem_wdata", mem_wdata, wdata[gi*DW +: DW]);
               ref_mem[ga] = wdata[gi*DW +: DW];
            end else begin
               rq.push_back('{due: cyc + 1, idx: gi, data: ref_mem[ga]});
            end
         end

         if (!req[2] || eg[2])                 m_wait = 0;
         else if (m_mode == M_RUN && m_wait < LIM) m_wait++;

         case (m_mode)
            M_RUN:   if (halt_req) m_mode = M_DRAIN;
            M_DRAIN: if (!req[0] && rq.size() == 0) m_mode = M_HALT;
            default: if (resume) m_mode = M_RUN;
         endcase
         gseen = eg;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req = req & ~gseen;
   endtask

   task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      we[i]  = w;
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic wait_idle(input string name);
      for (int n = 0; n < 60 && req != 0; n++) tick();
      if (req != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: req still %0b, required 0", name, req);
      end
      tick();
      tick();
   endtask

   initial begin : stim
      int start, rc;
      for (int i = 0; i < 1024; i++) begin
         dev_mem[i] <= 32'hA5A5_0000 ^ (i * 32'h0001_0203);
         ref_mem[i] =  32'hA5A5_0000 ^ (i * 32'h0001_0203);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Data and fetch reads together: data first, then fetch
      issue(0, 1'b0, 10'h010, '0);
      issue(1, 1'b0, 10'h020, '0);
      wait_idle("two_reads");

      // Loader starvation against a continuously requesting fetch
      issue(1, 1'b0, 10'h005, '0);
      issue(2, 1'b0, 10'h006, '0);
      start = cyc + 1;
      for (int n = 0; n < 20 && req[2]; n++) begin
         tick();
         if (!req[1]) issue(1, 1'b0, 10'(n), '0);
      end
      tick();
      chk("starve_load_cycle", 64'(last_gnt_cyc[2] - start), 64'(LIM));
      chk("fetch_after_force", 64'(last_gnt_cyc[1] - start), 64'(LIM + 1));
      wait_idle("starve");

      // Write then read back the top word
      issue(0, 1'b1, 10'h3FF, 32'hDEADBEEF);
      wait_idle("write_top");
      issue(0, 1'b0, 10'h3FF, '0);
      wait_idle("read_top");

      // Halt with data and fetch pending, loader write while halted, then resume
      issue(0, 1'b0, 10'h011, '0);
      issue(1, 1'b0, 10'h021, '0);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      issue(0, 1'b0, 10'h012, '0);
      for (int n = 0; n < 30 && !halted; n++) tick();
      chk("halted_reached", halted, 1);
      chk("fetch_held", req[1], 1);
      issue(2, 1'b1, 10'h030, 32'h1234_5678);
      for (int n = 0; n < 10 && req[2]; n++) tick();
      chk("loader_done", req[2], 0);
      resume = 1'b1;
      rc = cyc + 1;
      tick();
      resume = 1'b0;
      tick();
      chk("fetch_after_resume", 64'(last_gnt_cyc[1] - rc), 64'(1));
      wait_idle("halt_seq");

      // Reset in the cycle after a read grant, with a fetch left pending
      issue(0, 1'b0, 10'h030, '0);
      tick();
      issue(1, 1'b0, 10'h031, '0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_idle("after_reset");

      // Randomized traffic with occasional halt/resume
      for (int n = 0; n < 1500; n++) begin
         tick();
         halt_req = ($urandom_range(0, 40) == 0);
         resume   = halted && ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 3; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0)
               issue(i, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                     $urandom);
         end
      end

      halt_req = 1'b0;
      for (int n = 0; n < 200 && (req != 0 || halted); n++) begin
         tick();
         resume = halted;
      end
      resume = 1'b0;
      wait_idle("final_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
